// File: rtl/i2c_reg_xfer_sequencer.sv
// Turns one register read/write request into the START/address/data/STOP command
// stream for a byte-level I2C master engine. Define I2C_SEQ_RETRY_EN for NACK retries.
module i2c_reg_xfer_sequencer #(
    parameter logic [6:0] SLAVE_ADDR = 7'h55,
    parameter int         MAX_RETRY  = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rw,
    input  logic [7:0] req_reg,
    input  logic [7:0] req_wdata,
    output logic       done,
    output logic       done_err,
    output logic [7:0] done_rdata,
    output logic       busy,
    output logic       core_cmd_valid,
    input  logic       core_cmd_ready,
    output logic [2:0] core_cmd_op,
    output logic [7:0] core_cmd_wdata,
    input  logic       core_done,
    input  logic       core_nack,
    input  logic [7:0] core_rdata
);

    localparam logic [2:0] OP_START     = 3'd0;
    localparam logic [2:0] OP_WRITE     = 3'd1;
    localparam logic [2:0] OP_READ_NACK = 3'd3;
    localparam logic [2:0] OP_STOP      = 3'd4;

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_DEV_W,
        S_REG,
        S_WDATA,
        S_RSTART,
        S_DEV_R,
        S_RDATA,
        S_STOP,
        S_DONE
    } state_t;

    state_t     state, state_nx;
    logic       waiting, waiting_nx;
    logic       rw_q, rw_nx;
    logic [7:0] reg_q, reg_nx;
    logic [7:0] wdata_q, wdata_nx;
    logic [7:0] rdata_q, rdata_nx;
    logic       err, err_nx;
    logic       retry_ok;

`ifdef I2C_SEQ_RETRY_EN
    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    logic [RETRY_W-1:0] retry_cnt;

    assign retry_ok = (int'(retry_cnt) < MAX_RETRY);

    // Counts NACK-triggered restarts of the current request; a fresh request starts at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retry_cnt <= '0;
        end else if (state == S_IDLE && req_valid) begin
            retry_cnt <= '0;
        end else if (state == S_STOP && waiting && core_done && err && retry_ok) begin
            retry_cnt <= retry_cnt + 1'b1;
        end
    end
`else
    // Retries compiled out: a NACK always finishes the request with an error.
    assign retry_ok = (MAX_RETRY < 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            waiting <= 1'b0;
            rw_q    <= 1'b0;
            reg_q   <= 8'h00;
            wdata_q <= 8'h00;
            rdata_q <= 8'h00;
            err     <= 1'b0;
        end else begin
            state   <= state_nx;
            waiting <= waiting_nx;
            rw_q    <= rw_nx;
            reg_q   <= reg_nx;
            wdata_q <= wdata_nx;
            rdata_q <= rdata_nx;
            err     <= err_nx;
        end
    end

    // Every command state has an issue half (valid until ready) and a wait half (until core_done).
    always_comb begin
        state_nx   = state;
        waiting_nx = waiting;
        rw_nx      = rw_q;
        reg_nx     = reg_q;
        wdata_nx   = wdata_q;
        rdata_nx   = rdata_q;
        err_nx     = err;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    rw_nx      = req_rw;
                    reg_nx     = req_reg;
                    wdata_nx   = req_wdata;
                    err_nx     = 1'b0;
                    waiting_nx = 1'b0;
                    state_nx   = S_START;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                if (!waiting) begin
                    if (core_cmd_ready) begin
                        waiting_nx = 1'b1;
                    end
                end else if (core_done) begin
                    waiting_nx = 1'b0;
                    case (state)
                        S_START:  state_nx = S_DEV_W;
                        S_DEV_W:  state_nx = S_REG;
                        S_REG:    state_nx = rw_q ? S_RSTART : S_WDATA;
                        S_WDATA:  state_nx = S_STOP;
                        S_RSTART: state_nx = S_DEV_R;
                        S_DEV_R:  state_nx = S_RDATA;
                        S_RDATA: begin
                            rdata_nx = core_rdata;
                            state_nx = S_STOP;
                        end
                        S_STOP: begin
                            if (err && retry_ok) begin
                                err_nx   = 1'b0;
                                state_nx = S_START;
                            end else begin
                                state_nx = S_DONE;
                            end
                        end
                        default: state_nx = S_IDLE;
                    endcase
                    if (core_nack && (state == S_DEV_W || state == S_REG ||
                                      state == S_WDATA || state == S_DEV_R)) begin
                        err_nx   = 1'b1;
                        state_nx = S_STOP;
                    end
                end
            end
        endcase
    end

    always_comb begin
        core_cmd_op    = OP_START;
        core_cmd_wdata = 8'h00;
        case (state)
            S_START, S_RSTART: core_cmd_op = OP_START;
            S_DEV_W: begin
                core_cmd_op    = OP_WRITE;
                core_cmd_wdata = {SLAVE_ADDR, 1'b0};
            end
            S_REG: begin
                core_cmd_op    = OP_WRITE;
                core_cmd_wdata = reg_q;
            end
            S_WDATA: begin
                core_cmd_op    = OP_WRITE;
                core_cmd_wdata = wdata_q;
            end
            S_DEV_R: begin
                core_cmd_op    = OP_WRITE;
                core_cmd_wdata = {SLAVE_ADDR, 1'b1};
            end
            S_RDATA: core_cmd_op = OP_READ_NACK;
            S_STOP:  core_cmd_op = OP_STOP;
            default: core_cmd_op = OP_START;
        endcase
    end

    assign req_ready      = (state == S_IDLE);
    assign busy           = (state != S_IDLE);
    assign done           = (state == S_DONE);
    assign done_err       = (state == S_DONE) && err;
    assign done_rdata     = rdata_q;
    assign core_cmd_valid = (state != S_IDLE) && (state != S_DONE) && !waiting;

endmodule

// File: tb/tb_i2c_reg_xfer_sequencer.sv
// Randomised scoreboard bench for i2c_reg_xfer_sequencer with a behavioural byte engine.
// Build with I2C_SEQ_RETRY_EN defined to match a retry-enabled DUT.
module tb_i2c_reg_xfer_sequencer;

`ifdef I2C_SEQ_RETRY_EN
    localparam int RETRIES = 3;
`else
    localparam int RETRIES = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_rw = 1'b0;
    logic [7:0] req_reg = 8'h00;
    logic [7:0] req_wdata = 8'h00;
    logic       done;
    logic       done_err;
    logic [7:0] done_rdata;
    logic       busy;
    logic       core_cmd_valid;
    logic       core_cmd_ready = 1'b0;
    logic [2:0] core_cmd_op;
    logic [7:0] core_cmd_wdata;
    logic       core_done = 1'b0;
    logic       core_nack = 1'b0;
    logic [7:0] core_rdata = 8'h00;

    i2c_reg_xfer_sequencer #(.SLAVE_ADDR(7'h55), .MAX_RETRY(3)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_rw         (req_rw),
        .req_reg        (req_reg),
        .req_wdata      (req_wdata),
        .done           (done),
        .done_err       (done_err),
        .done_rdata     (done_rdata),
        .busy           (busy),
        .core_cmd_valid (core_cmd_valid),
        .core_cmd_ready (core_cmd_ready),
        .core_cmd_op    (core_cmd_op),
        .core_cmd_wdata (core_cmd_wdata),
        .core_done      (core_done),
        .core_nack      (core_nack),
        .core_rdata     (core_rdata)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [10:0] exp_cmd[$];
    logic [8:0]  exp_done[$];
    logic [7:0]  model_rdata = 8'h00;

    int         pol_nack_idx = 3;
    int         pol_nack_attempts = 0;
    logic [7:0] pol_rdata = 8'h00;
    int         eng_attempt = 0;
    bit         stall_armed = 1'b0;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected command stream and completion for one request, from the protocol rules.
    task automatic model_push(input bit rw, input logic [7:0] rg, input logic [7:0] wd,
                              input int nidx, input int natt, input logic [7:0] rd);
        logic [7:0] bytes [3];
        bit nacked;
        nacked   = 1'b0;
        bytes[0] = 8'hAA;
        bytes[1] = rg;
        bytes[2] = rw ? 8'hAB : wd;
        for (int a = 0; a <= RETRIES; a++) begin
            nacked = 1'b0;
            exp_cmd.push_back({3'd0, 8'h00});
            for (int i = 0; i < 3; i++) begin
                if (rw && i == 2) exp_cmd.push_back({3'd0, 8'h00});
                exp_cmd.push_back({3'd1, bytes[i]});
                if (a < natt && i == nidx) begin
                    nacked = 1'b1;
                    break;
                end
            end
            if (!nacked && rw) exp_cmd.push_back({3'd3, 8'h00});
            exp_cmd.push_back({3'd4, 8'h00});
            if (!nacked) break;
        end
        if (!nacked && rw) model_rdata = rd;
        exp_done.push_back({nacked, model_rdata});
    endtask

    task automatic apply_stimulus(input bit rw, input logic [7:0] rg, input logic [7:0] wd,
                                  input logic [7:0] rd, input int nidx, input int natt,
                                  input bit stall);
        bit rdy;
        int guard;
        req_valid = 1'b1;
        req_rw    = rw;
        req_reg   = rg;
        req_wdata = wd;
        guard     = 0;
        do begin
            rdy = req_ready;
            @(posedge clk);
            #1;
            guard++;
        end while (!rdy && guard < 3000);
        req_valid = 1'b0;
        req_rw    = 1'($urandom);
        req_reg   = 8'($urandom);
        req_wdata = 8'($urandom);
        if (!rdy) begin
            n_cmp++;
            n_err++;
            $display("[TB] FAIL accept_timeout: got no req_ready, expected acceptance");
            return;
        end
        pol_nack_idx      = nidx;
        pol_nack_attempts = natt;
        pol_rdata         = rd;
        eng_attempt       = 0;
        stall_armed       = stall;
        model_push(rw, rg, wd, nidx, natt, rd);
        check_output("busy_after_accept", 32'(busy), 32'd1);
        check_output("ready_after_accept", 32'(req_ready), 32'd0);
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while ((busy || exp_done.size() != 0) && guard < 5000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 5000) begin
            n_cmp++;
            n_err++;
            $display("[TB] FAIL idle_timeout: got busy=%0d pending=%0d, expected idle", busy, exp_done.size());
        end
        @(posedge clk);
        #1;
    endtask

    // Byte engine: grants commands after random delays and answers from the active policy.
    initial begin
        int         eng_phase;
        int         busy_cnt;
        int         wr_idx;
        int         stall_left;
        logic [2:0] lat_op;
        eng_phase  = 0;
        busy_cnt   = 0;
        wr_idx     = 0;
        stall_left = 0;
        lat_op     = 3'd0;
        forever begin
            @(posedge clk);
            #1;
            core_done = 1'b0;
            core_nack = 1'b0;
            if (!rst_n) begin
                eng_phase      = 0;
                core_cmd_ready = 1'b0;
                wr_idx         = 0;
                stall_left     = 0;
            end else if (eng_phase == 0) begin
                core_cmd_ready = 1'b0;
                if (stall_left > 0) begin
                    check_output("stall_valid", 32'(core_cmd_valid), 32'd1);
                    check_output("stall_op", 32'(core_cmd_op), 32'd1);
                    check_output("stall_wdata", 32'(core_cmd_wdata), 32'h34);
                    stall_left--;
                end else if (core_cmd_valid) begin
                    if (stall_armed && core_cmd_op == 3'd1 && core_cmd_wdata == 8'h34) begin
                        stall_armed = 1'b0;
                        stall_left  = 10;
                    end else if ($urandom_range(0, 2) != 0) begin
                        core_cmd_ready = 1'b1;
                        lat_op         = core_cmd_op;
                        busy_cnt       = $urandom_range(0, 3);
                        eng_phase      = 1;
                    end
                end else if ($urandom_range(0, 3) == 0) begin
                    core_done  = 1'b1;
                    core_nack  = 1'($urandom);
                    core_rdata = 8'($urandom);
                end
            end else begin
                core_cmd_ready = 1'b0;
                if (busy_cnt > 0) begin
                    busy_cnt--;
                end else begin
                    core_done  = 1'b1;
                    core_rdata = 8'($urandom);
                    eng_phase  = 0;
                    case (lat_op)
                        3'd1: begin
                            core_nack = (eng_attempt < pol_nack_attempts) && (wr_idx == pol_nack_idx);
                            wr_idx++;
                        end
                        3'd2, 3'd3: core_rdata = pol_rdata;
                        3'd4: begin
                            wr_idx = 0;
                            eng_attempt++;
                        end
                        default: core_nack = 1'($urandom);
                    endcase
                end
            end
        end
    end

    // Monitor: pops expectations when the DUT hands over a command or signals done.
    initial begin
        bit          was_done;
        logic [10:0] ec;
        logic [8:0]  ed;
        was_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                was_done = 1'b0;
                continue;
            end
            if (was_done) begin
                check_output("busy_after_done", 32'(busy), 32'd0);
                check_output("ready_after_done", 32'(req_ready), 32'd1);
                was_done = 1'b0;
            end
            if (core_cmd_valid && core_cmd_ready) begin
                if (exp_cmd.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("[TB] FAIL extra_cmd: got op=%0d wdata=0x%0h, expected no command", core_cmd_op, core_cmd_wdata);
                end else begin
                    ec = exp_cmd.pop_front();
                    if (ec[10:8] == 3'd1)
                        check_output("cmd_write", {21'd0, core_cmd_op, core_cmd_wdata}, {21'd0, ec});
                    else
                        check_output("cmd_op", 32'(core_cmd_op), 32'(ec[10:8]));
                end
            end
            if (done) begin
                if (exp_done.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("[TB] FAIL extra_done: got done=1, expected no completion");
                end else begin
                    ed = exp_done.pop_front();
                    check_output("done_err", 32'(done_err), 32'(ed[8]));
                    check_output("done_rdata", 32'(done_rdata), 32'(ed[7:0]));
                    check_output("busy_during_done", 32'(busy), 32'd1);
                end
                was_done = 1'b1;
            end
        end
    end

    task automatic check_reset_values(input string tag);
        check_output({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        check_output({tag, "_done"}, 32'(done), 32'd0);
        check_output({tag, "_done_err"}, 32'(done_err), 32'd0);
        check_output({tag, "_done_rdata"}, 32'(done_rdata), 32'd0);
        check_output({tag, "_busy"}, 32'(busy), 32'd0);
        check_output({tag, "_cmd_valid"}, 32'(core_cmd_valid), 32'd0);
        check_output({tag, "_cmd_op"}, 32'(core_cmd_op), 32'd0);
        check_output({tag, "_cmd_wdata"}, 32'(core_cmd_wdata), 32'd0);
    endtask

    initial begin
        int guard;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        apply_stimulus(1'b0, 8'h01, 8'hFF, 8'h00, 3, 0, 1'b0);
        wait_idle();
        apply_stimulus(1'b1, 8'h00, 8'h00, 8'hCD, 3, 0, 1'b0);
        wait_idle();
        apply_stimulus(1'b0, 8'h01, 8'h55, 8'h00, 0, 99, 1'b0);
        wait_idle();
        apply_stimulus(1'b0, 8'h02, 8'h66, 8'h00, 1, 1, 1'b0);
        wait_idle();
        apply_stimulus(1'b1, 8'h03, 8'h00, 8'h5A, 2, 99, 1'b0);
        wait_idle();
        apply_stimulus(1'b0, 8'h03, 8'h34, 8'h00, 3, 0, 1'b1);
        wait_idle();

        // Reset while the read byte is outstanding.
        apply_stimulus(1'b1, 8'h00, 8'h00, 8'h77, 3, 0, 1'b0);
        guard = 0;
        while (!(core_cmd_op == 3'd3 && !core_cmd_valid && busy) && guard < 2000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check_output("rdata_wait_reached", 32'(guard < 2000), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_values("midreset");
        exp_cmd.delete();
        exp_done.delete();
        model_rdata = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        apply_stimulus(1'b0, 8'h02, 8'hAA, 8'h00, 3, 0, 1'b0);
        wait_idle();

        for (int n = 0; n < 40; n++) begin
            apply_stimulus(1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                           $urandom_range(0, 5), $urandom_range(0, 4), 1'b0);
        end
        wait_idle();

        check_output("cmd_queue_empty", 32'(exp_cmd.size()), 32'd0);
        check_output("done_queue_empty", 32'(exp_done.size()), 32'd0);
        check_output("final_idle", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
